// File: rtl/alu_serial_sequencer.sv
// Bit-serial initiator for an external 1-bit ALU slice: walks a WIDTH-bit request LSB first,
// chains the slice carry between cycles and assembles result, carry, overflow, zero and SLT.
module alu_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carry_in,
  output logic             slice_less,
  output logic [2:0]       slice_alu_op,
  input  logic             slice_result,
  input  logic             slice_carry_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carryOut;
  logic             r_overflow;
  logic             r_zero;
  logic             r_err;

  logic             w_accept;
  logic             w_lastBit;
  logic             w_legal;
  logic             w_arith;
  logic             w_addSub;
  logic             w_ovf;
  logic [2:0]       w_sliceOp;
  logic [WIDTH-1:0] w_finalResult;

  // A start in DONE is accepted too, which gives back-to-back operation.
  assign w_accept  = start && (r_state != RUN);
  assign w_lastBit = (r_state == RUN) && (r_idx == IDX_W'(WIDTH - 1));
  assign w_legal   = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_ADD) ||
                     (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT);
  assign w_addSub  = (r_op == OP_ADD) || (r_op == OP_SUB);
  // On the MSB cycle r_carry is the carry into the MSB, so this is the signed overflow.
  assign w_ovf     = r_carry ^ slice_carry_out;

  always_comb begin
    w_sliceOp = r_op;
    if (!w_legal) begin
      w_sliceOp = OP_AND;
    end else if (r_op == OP_SLT) begin
      w_sliceOp = OP_SUB;
    end
  end

  always_comb begin
    w_finalResult        = r_result;
    w_finalResult[r_idx] = slice_result;
    case (r_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ;
      OP_SLT:  w_finalResult = {{(WIDTH-1){1'b0}}, slice_result ^ w_ovf};
      default: w_finalResult = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == RUN);
    done           = (r_state == DONE);
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_carry_in = 1'b0;
    slice_less     = 1'b0;
    slice_alu_op   = 3'b000;
    if (r_state == RUN) begin
      slice_a        = r_a[r_idx];
      slice_b        = r_b[r_idx];
      slice_carry_in = r_carry;
      slice_alu_op   = w_sliceOp;
    end
  end

  // Operand capture, per-bit sampling, and final flag evaluation on the MSB edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_a        <= a_in;
      r_b        <= b_in;
      r_op       <= alu_op;
      r_idx      <= '0;
      r_carry    <= alu_op[2];
      r_result   <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
      r_err      <= 1'b0;
    end else if (r_state == RUN) begin
      r_result[r_idx] <= slice_result;
      r_carry         <= slice_carry_out;
      r_idx           <= r_idx + IDX_W'(1);
      if (w_lastBit) begin
        r_result   <= w_finalResult;
        r_zero     <= (w_finalResult == '0);
        r_err      <= !w_legal;
        r_carryOut <= w_arith ? slice_carry_out : 1'b0;
        r_overflow <= w_addSub ? w_ovf : 1'b0;
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer: a behavioural 1-bit slice closes the loop and a
// 32-bit arithmetic reference model predicts every completed operation.
`timescale 1ns/1ps
module tb_alu_serial_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic [2:0]       alu_op = 3'b000;
  logic             busy, done, carry_out, overflow, zero, err;
  logic [WIDTH-1:0] result;
  logic             slice_a, slice_b, slice_carry_in, slice_less;
  logic [2:0]       slice_alu_op;
  logic             slice_result, slice_carry_out;

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .alu_op(alu_op),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .err(err), .slice_a(slice_a), .slice_b(slice_b),
    .slice_carry_in(slice_carry_in), .slice_less(slice_less), .slice_alu_op(slice_alu_op),
    .slice_result(slice_result), .slice_carry_out(slice_carry_out)
  );

  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice: b inverted when AluOp[2] is set.
  logic w_bEff;
  assign w_bEff = slice_alu_op[2] ? ~slice_b : slice_b;
  assign slice_carry_out = (slice_a & w_bEff) | (slice_a & slice_carry_in) | (w_bEff & slice_carry_in);
  always_comb begin
    case (slice_alu_op[1:0])
      2'b00:   slice_result = slice_a & w_bEff;
      2'b01:   slice_result = slice_a | w_bEff;
      2'b10:   slice_result = slice_a ^ w_bEff ^ slice_carry_in;
      default: slice_result = slice_less;
    endcase
  end

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        err;
    int          acceptEdge;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;

  always @(posedge clk) cyc++;

  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t        e;
    logic [32:0] s;
    e.result = '0; e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.acceptEdge = 0;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.result = s[31:0];
        e.carry  = s[32];
        e.ovf    = (a[31] == b[31]) && (e.result[31] != a[31]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.result = s[31:0];
        e.carry  = s[32];
        e.ovf    = (a[31] != b[31]) && (e.result[31] != a[31]);
      end
      3'b111: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.carry  = s[32];
        e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse pops one prediction.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("result",    result,    e.result);
        checkOutput("carry_out", {31'd0, carry_out}, {31'd0, e.carry});
        checkOutput("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
        checkOutput("zero",      {31'd0, zero},      {31'd0, e.zero});
        checkOutput("err",       {31'd0, err},       {31'd0, e.err});
        checkOutput("latency",   cyc, e.acceptEdge + WIDTH);
      end
    end
  end

  task automatic waitNotBusy();
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) checkOutput("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    waitNotBusy();
    a_in   = a;
    b_in   = b;
    alu_op = op;
    start  = 1'b1;
    e = refModel(a, b, op);
    e.acceptEdge = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drainQueue();
    int guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"},   {31'd0, busy},   32'd0);
    checkOutput({tag, "_done"},   {31'd0, done},   32'd0);
    checkOutput({tag, "_result"}, result,          32'd0);
    checkOutput({tag, "_zero"},   {31'd0, zero},   32'd1);
    checkOutput({tag, "_flags"},  {29'd0, carry_out, overflow, err}, 32'd0);
    checkOutput({tag, "_slice"},  {25'd0, slice_a, slice_b, slice_carry_in, slice_less, slice_alu_op}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] special [5];
    special = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  function automatic logic [2:0] pickOp();
    logic [2:0] legal [5];
    legal = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    if ($urandom_range(0, 19) == 0) return 3'($urandom_range(3, 5));
    return legal[$urandom_range(0, 4)];
  endfunction

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("reset");

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
    applyStimulus(32'd5, 32'd7, 3'b110);
    applyStimulus(32'd9, 32'd9, 3'b110);
    applyStimulus(32'hFFFF_FFFD, 32'd2, 3'b111);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 3'b111);
    applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
    applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 3'b101);
    applyStimulus(32'h0000_0003, 32'h0000_0001, 3'b010);

    // Garbage start pulses while a SUB is running must not disturb it.
    applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b110);
    for (int i = 0; i < 5; i++) begin
      a_in = $urandom; b_in = $urandom; alu_op = 3'b001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001);
    drainQueue();

    // Reset during bit 10 of an ADD: no done, outputs back to reset values.
    a_in = 32'hDEAD_BEEF; b_in = 32'h0101_0101; alu_op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("midrun_reset");
    repeat (40) @(negedge clk);
    checkOutput("midrun_reset_busy_later", {31'd0, busy}, 32'd0);

    // Reset and start together: reset wins.
    a_in = 32'h0000_0001; b_in = 32'h0000_0001; alu_op = 3'b010;
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checkIdleOutputs("reset_and_start");
    repeat (40) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(pickOperand(), pickOperand(), pickOp());
      if ($urandom_range(0, 3) == 0) waitNotBusy();
    end
    drainQueue();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
